// File: rtl/fifo_pop_stage.sv
// ============================================================================
// Module   : fifo_pop_stage
// Purpose  : Read side of the circular buffer. Pulls the head item and offers
//            it as a registered valid/ready stream through a 2-entry skid.
//            Optional statistics counters: FIFO_POP_STAGE_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_pop_stage #(
  parameter type T = logic [31:0]
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fifo_empty,
  input  T            fifo_read_data,
  output logic        fifo_read_en,
  input  logic        flush,
  output logic        out_valid,
  output T            out_data,
  input  logic        out_ready,
  output logic [1:0]  count
`ifdef FIFO_POP_STAGE_STATS_EN
  ,
  output logic [31:0] pop_count,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t r_state;
  T       r_head;
  T       r_skid;
  logic   w_push;
  logic   w_pop;

  // Read enable looks only at held state, so out_ready never reaches the buffer.
  assign w_push       = !fifo_empty && !flush && (r_state != ST_TWO);
  assign w_pop        = out_valid && out_ready && !flush;
  assign fifo_read_en = w_push;
  assign out_valid    = (r_state != ST_EMPTY);
  assign out_data     = r_head;
  assign count        = r_state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_EMPTY;
      r_head  <= '0;
      r_skid  <= '0;
    end else if (flush) begin
      r_state <= ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_push) begin
            r_head  <= fifo_read_data;
            r_state <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_push && w_pop) begin
            r_head <= fifo_read_data;
          end else if (w_push) begin
            r_skid  <= fifo_read_data;
            r_state <= ST_TWO;
          end else if (w_pop) begin
            r_state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_pop) begin
            r_head  <= r_skid;
            r_state <= ST_ONE;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

`ifdef FIFO_POP_STAGE_STATS_EN
  logic [31:0] r_pop_count;
  logic [31:0] r_stall_count;

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pop_count   <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_pop) begin
        r_pop_count <= r_pop_count + 32'd1;
      end
      if (out_valid && !out_ready && !flush) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
    end
  end

  assign pop_count   = r_pop_count;
  assign stall_count = r_stall_count;
`endif

endmodule

`default_nettype wire
